// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: default operand width
// and the two-state controller encoding.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, with borrow-out bo.
// Purely combinational so it can also be chained into a ripple subtractor.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    // Difference bit and borrow-out for a single bit position
    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// behind a start/done handshake. Results are only updated on completion.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // The counter carries one spare bit so it can never wrap before WIDTH
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             bit_d;
    logic             bit_bo;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_fs (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .bi (br),
        .d  (bit_d),
        .bo (bit_bo)
    );

    // Result register as it will look once the current bit is shifted in
    always_comb begin
        res_next = {bit_d, res_sr[WIDTH-1:1]};
    end

    // Capture operands on start, then process one bit per clock until done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        br     <= bin;
                        res_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    br     <= bit_bo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        diff  <= res_next;
                        bout  <= bit_bo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a cycle-level behavioural model
// (plain arithmetic plus a countdown) is compared on every falling edge, and
// directed vectors pin the model with hand-computed results.
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // behavioural model state
    bit           model_busy = 1'b0;
    bit           model_done = 1'b0;
    logic [W-1:0] model_diff = '0;
    bit           model_bout = 1'b0;
    logic [W-1:0] pend_diff = '0;
    bit           pend_bout = 1'b0;
    int           remaining = 0;
    int           model_dones = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    // free-running clock
    always #5 clk = ~clk;

    // Model: a - b - bin computed in W+1 bits, result released W edges later
    always @(posedge clk or negedge rst_n) begin
        logic [W:0] full;
        if (!rst_n) begin
            model_busy = 1'b0;
            model_done = 1'b0;
            model_diff = '0;
            model_bout = 1'b0;
            remaining  = 0;
        end else begin
            model_done = 1'b0;
            if (model_busy) begin
                remaining = remaining - 1;
                if (remaining == 0) begin
                    model_busy = 1'b0;
                    model_done = 1'b1;
                    model_diff = pend_diff;
                    model_bout = pend_bout;
                    model_dones++;
                end
            end else if (start) begin
                full       = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
                pend_diff  = full[W-1:0];
                pend_bout  = full[W];
                model_busy = 1'b1;
                remaining  = W;
            end
        end
    end

    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Continuous comparison of every output against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("cyc_busy", int'(busy), int'(model_busy));
            checkOutput("cyc_done", int'(done), int'(model_done));
            checkOutput("cyc_diff", int'(diff), int'(model_diff));
            checkOutput("cyc_bout", int'(bout), int'(model_bout));
        end
    end

    // Wait (bounded) for done; returns negedges waited and busy cycles seen
    task automatic waitDone(output int n, output int busy_cycles);
        n = 0;
        busy_cycles = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) busy_cycles++;
        end while (!done && n < 20);
        if (!done) checkOutput("done_timeout", 0, 1);
    endtask

    // Issue one operation and check its result against literal expectations
    task automatic applyStimulus(input int av, input int bv, input int binv,
                                 input int expd, input int expb);
        int n, bc;
        @(negedge clk);
        a = W'(av); b = W'(bv); bin = binv[0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        bc = busy ? 1 : 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
        end
        if (!done) begin
            checkOutput("done_timeout", 0, 1);
        end else begin
            checkOutput("latency", n, W + 1);
            checkOutput("busy_cycles", bc, W);
            checkOutput("diff_lit", int'(diff), expd);
            checkOutput("bout_lit", int'(bout), expb);
            checkOutput("model_diff_lit", int'(model_diff), expd);
            checkOutput("model_bout_lit", int'(model_bout), expb);
        end
    endtask

    initial begin
        int n, bc;
        $display("[TB] serial_subtractor bench, WIDTH=%0d", W);

        // reset state
        #12;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_diff", int'(diff), 0);
        checkOutput("rst_bout", int'(bout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // directed vectors
        applyStimulus(8, 3, 0, 5, 0);
        applyStimulus(3, 5, 0, 14, 1);
        applyStimulus(5, 2, 1, 2, 0);
        applyStimulus(0, 0, 1, 15, 1);
        applyStimulus(15, 15, 0, 0, 0);
        applyStimulus(15, 0, 0, 15, 0);

        // start while busy is ignored; start in the done cycle is accepted
        @(negedge clk);
        a = 4'd12; b = 4'd7; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd1; b = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        waitDone(n, bc);
        checkOutput("ignored_diff", int'(diff), 5);
        checkOutput("ignored_bout", int'(bout), 0);
        a = 4'd10; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_busy", int'(busy), 1);
        checkOutput("b2b_done", int'(done), 0);
        waitDone(n, bc);
        checkOutput("b2b_latency", n, W);
        checkOutput("b2b_diff", int'(diff), 7);
        checkOutput("b2b_bout", int'(bout), 0);

        // asynchronous reset mid-operation
        @(negedge clk);
        a = 4'd9; b = 4'd4; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_done", int'(done), 0);
        checkOutput("midrst_diff", int'(diff), 0);
        checkOutput("midrst_bout", int'(bout), 0);
        n = 0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done) n++;
        end
        checkOutput("midrst_no_done", n, 0);
        rst_n = 1'b1;
        applyStimulus(9, 4, 0, 5, 0);

        // randomized traffic: random starts, operands changing every cycle
        n = model_dones;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) != 0);
            a     = W'($urandom);
            b     = W'($urandom);
            bin   = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (W + 2) @(negedge clk);
        checkOutput("random_ops_seen", int'(model_dones - n > 20), 1);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
